// File: rtl/udp_reg_ring_arbiter_pkg.sv
// Shared constants, state encodings and helpers for the register-ring arbiter.
package udp_reg_ring_arbiter_pkg;

    localparam int UDP_REG_ADDR_WIDTH  = 23;
    localparam int CPCI_NF2_DATA_WIDTH = 32;

    localparam logic [CPCI_NF2_DATA_WIDTH-1:0] REG_RING_ERR_DATA = 32'hDEAD_BEEF;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef struct packed {
        logic                           rd_wr_L;
        logic [UDP_REG_ADDR_WIDTH-1:0]  addr;
        logic [CPCI_NF2_DATA_WIDTH-1:0] data;
    } reg_req_t;

    // Ceiling log2, never less than 1 so counters always have a bit.
    function automatic int log2_func(input int value);
        int w;
        w = 1;
        for (int i = 1; i < 32; i++) begin
            if ((1 << i) < value) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/udp_reg_ring_arbiter_if.sv
// Requester-side and ring-side signal bundle; master is the arbiter, slave is its environment.
interface udp_reg_ring_arbiter_if #(
    parameter int NUM_REQ           = 4,
    parameter int UDP_REG_SRC_WIDTH = 2
);
    import udp_reg_ring_arbiter_pkg::*;

    logic [NUM_REQ-1:0]                     req_valid;
    logic [NUM_REQ-1:0]                     req_rd_wr_L;
    logic [NUM_REQ*UDP_REG_ADDR_WIDTH-1:0]  req_addr;
    logic [NUM_REQ*CPCI_NF2_DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]                     req_done;
    logic [CPCI_NF2_DATA_WIDTH-1:0]         rsp_data;
    logic                                   rsp_err;

    logic                           reg_req_out;
    logic                           reg_ack_out;
    logic                           reg_rd_wr_L_out;
    logic [UDP_REG_ADDR_WIDTH-1:0]  reg_addr_out;
    logic [CPCI_NF2_DATA_WIDTH-1:0] reg_data_out;
    logic [UDP_REG_SRC_WIDTH-1:0]   reg_src_out;

    logic                           reg_req_in;
    logic                           reg_ack_in;
    logic                           reg_rd_wr_L_in;
    logic [UDP_REG_ADDR_WIDTH-1:0]  reg_addr_in;
    logic [CPCI_NF2_DATA_WIDTH-1:0] reg_data_in;
    logic [UDP_REG_SRC_WIDTH-1:0]   reg_src_in;

    modport master (
        input  req_valid, req_rd_wr_L, req_addr, req_data,
        output req_done, rsp_data, rsp_err,
        output reg_req_out, reg_ack_out, reg_rd_wr_L_out, reg_addr_out, reg_data_out, reg_src_out,
        input  reg_req_in, reg_ack_in, reg_rd_wr_L_in, reg_addr_in, reg_data_in, reg_src_in
    );

    modport slave (
        output req_valid, req_rd_wr_L, req_addr, req_data,
        input  req_done, rsp_data, rsp_err,
        input  reg_req_out, reg_ack_out, reg_rd_wr_L_out, reg_addr_out, reg_data_out, reg_src_out,
        output reg_req_in, reg_ack_in, reg_rd_wr_L_in, reg_addr_in, reg_data_in, reg_src_in
    );

endinterface

// File: rtl/udp_reg_ring_arbiter_rr.sv
// Combinational round-robin picker: first set request strictly after last_grant, circularly.
module reg_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   last_grant_i,
    output logic [IDX_W-1:0]   grant_o,
    output logic               any_req_o
);

    logic [IDX_W-1:0]   cand_idx [NUM_REQ];
    logic [NUM_REQ-1:0] cand_req;

    // Candidate gi is the requester gi+1 places after the last winner.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_cand
            assign cand_idx[gi] = IDX_W'((int'(last_grant_i) + 1 + gi) % NUM_REQ);
            assign cand_req[gi] = req_i[cand_idx[gi]];
        end
    endgenerate

    always_comb begin
        grant_o = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (cand_req[i]) begin
                grant_o = cand_idx[i];
            end
        end
    end

    assign any_req_o = |req_i;

endmodule

// File: rtl/udp_reg_ring_arbiter.sv
// Register-ring master: grants one requester round-robin, injects a one-cycle ring request
// and returns the echoed response (or an error on no-claim/timeout) to that requester.
module udp_reg_ring_arbiter
    import udp_reg_ring_arbiter_pkg::*;
#(
    parameter int NUM_REQ           = 4,
    parameter int UDP_REG_SRC_WIDTH = 2,
    parameter int TIMEOUT           = 128
) (
    input  logic                  clk,
    input  logic                  reset_n,
    udp_reg_ring_arbiter_if.master bus
);

    localparam int AW    = UDP_REG_ADDR_WIDTH;
    localparam int DW    = CPCI_NF2_DATA_WIDTH;
    localparam int IW    = UDP_REG_SRC_WIDTH;
    localparam int CNT_W = log2_func(TIMEOUT);

    localparam logic [IW-1:0]    LAST_GRANT_RST = IW'(NUM_REQ - 1);
    localparam logic [CNT_W-1:0] CNT_LAST       = CNT_W'(TIMEOUT - 1);

    logic [1:0]         state_q, state_d;
    logic [IW-1:0]      last_grant_q, last_grant_d;
    logic [IW-1:0]      grant_q, grant_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ring_req_q, ring_req_d;
    reg_req_t           ring_q, ring_d;
    logic [IW-1:0]      ring_src_q, ring_src_d;
    logic [NUM_REQ-1:0] req_done_q, req_done_d;
    logic [DW-1:0]      rsp_data_q, rsp_data_d;
    logic               rsp_err_q, rsp_err_d;

    logic [IW-1:0]      pick;
    logic               any_req;
    logic               ret_match;

    reg_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IW)
    ) u_rr (
        .req_i        (bus.req_valid),
        .last_grant_i (last_grant_q),
        .grant_o      (pick),
        .any_req_o    (any_req)
    );

    assign ret_match = bus.reg_req_in && (bus.reg_src_in == grant_q);

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        cnt_d        = cnt_q;
        ring_req_d   = 1'b0;
        ring_d       = '0;
        ring_src_d   = '0;
        req_done_d   = '0;
        rsp_data_d   = rsp_data_q;
        rsp_err_d    = rsp_err_q;

        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    grant_d        = pick;
                    last_grant_d   = pick;
                    cnt_d          = '0;
                    ring_req_d     = 1'b1;
                    ring_d.rd_wr_L = bus.req_rd_wr_L[pick];
                    ring_d.addr    = bus.req_addr[int'(pick)*AW +: AW];
                    ring_d.data    = bus.req_data[int'(pick)*DW +: DW];
                    ring_src_d     = pick;
                    state_d        = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // A return on the timeout cycle still completes normally.
                if (ret_match) begin
                    rsp_data_d = bus.reg_ack_in ? bus.reg_data_in : REG_RING_ERR_DATA;
                    rsp_err_d  = ~bus.reg_ack_in;
                    req_done_d = NUM_REQ'(1) << grant_q;
                    state_d    = ST_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    rsp_data_d = REG_RING_ERR_DATA;
                    rsp_err_d  = 1'b1;
                    req_done_d = NUM_REQ'(1) << grant_q;
                    state_d    = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            last_grant_q <= LAST_GRANT_RST;
            grant_q      <= '0;
            cnt_q        <= '0;
            ring_req_q   <= 1'b0;
            ring_q       <= '0;
            ring_src_q   <= '0;
            req_done_q   <= '0;
            rsp_data_q   <= '0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            cnt_q        <= cnt_d;
            ring_req_q   <= ring_req_d;
            ring_q       <= ring_d;
            ring_src_q   <= ring_src_d;
            req_done_q   <= req_done_d;
            rsp_data_q   <= rsp_data_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    assign bus.reg_req_out     = ring_req_q;
    assign bus.reg_ack_out     = 1'b0;
    assign bus.reg_rd_wr_L_out = ring_q.rd_wr_L;
    assign bus.reg_addr_out    = ring_q.addr;
    assign bus.reg_data_out    = ring_q.data;
    assign bus.reg_src_out     = ring_src_q;
    assign bus.req_done        = req_done_q;
    assign bus.rsp_data        = rsp_data_q;
    assign bus.rsp_err         = rsp_err_q;

endmodule

// File: tb/tb_udp_reg_ring_arbiter.sv
// Directed bench: arbiter driving a 3-stage ring model with one hw-reg block at address 0x000002.
module tb_udp_reg_ring_arbiter;
    import udp_reg_ring_arbiter_pkg::*;

    localparam int NR = 4;
    localparam int SW = 2;
    localparam int TO = 16;
    localparam int AW = UDP_REG_ADDR_WIDTH;
    localparam int DW = CPCI_NF2_DATA_WIDTH;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    udp_reg_ring_arbiter_if #(.NUM_REQ(NR), .UDP_REG_SRC_WIDTH(SW)) bus ();

    udp_reg_ring_arbiter #(
        .NUM_REQ           (NR),
        .UDP_REG_SRC_WIDTH (SW),
        .TIMEOUT           (TO)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct packed {
        logic          req;
        logic          ack;
        logic          rd_wr_L;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [SW-1:0] src;
    } ring_t;

    ring_t st0 = '0;
    ring_t st1 = '0;
    ring_t st2 = '0;
    ring_t inj = '0;
    ring_t ring_in;
    logic  inject_en  = 1'b0;
    logic  ring_break = 1'b0;

    function automatic ring_t hw_claim(input ring_t w);
        ring_t r;
        r = w;
        if (w.req && !w.ack && w.addr == 23'h000002) begin
            r.ack = 1'b1;
            if (w.rd_wr_L) r.data = 32'h1234_5678;
        end
        return r;
    endfunction

    // Ring stages are not reset so a return can stay in flight across a DUT reset.
    always @(posedge clk) begin
        st0 <= {bus.reg_req_out, bus.reg_ack_out, bus.reg_rd_wr_L_out,
                bus.reg_addr_out, bus.reg_data_out, bus.reg_src_out};
        st1 <= hw_claim(st0);
        st2 <= st1;
    end

    always_comb begin
        if (inject_en)       ring_in = inj;
        else if (ring_break) ring_in = '0;
        else                 ring_in = st2;
    end

    assign bus.reg_req_in     = ring_in.req;
    assign bus.reg_ack_in     = ring_in.ack;
    assign bus.reg_rd_wr_L_in = ring_in.rd_wr_L;
    assign bus.reg_addr_in    = ring_in.addr;
    assign bus.reg_data_in    = ring_in.data;
    assign bus.reg_src_in     = ring_in.src;

    int total = 0;
    int bad   = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic load_reqs(input int slot, input logic rd, input logic [AW-1:0] addr,
                             input logic [DW-1:0] data);
        for (int i = 0; i < NR; i++) begin
            if (i == slot) begin
                bus.req_rd_wr_L[i]        = rd;
                bus.req_addr[i*AW +: AW]  = addr;
                bus.req_data[i*DW +: DW]  = data;
            end else begin
                bus.req_rd_wr_L[i]        = ~rd;
                bus.req_addr[i*AW +: AW]  = 23'h007F00 + 23'(i);
                bus.req_data[i*DW +: DW]  = 32'hF0F0_0000 + 32'(i);
            end
        end
    endtask

    task automatic wait_grant(output int n, output bit ok);
        ok = 1'b0;
        n  = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            n++;
            if (bus.reg_req_out) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_done(input int start, output int lat, output bit ok);
        ok  = 1'b0;
        lat = start;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            lat++;
            if (bus.req_done != '0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic run_txn(input string tag, input logic [NR-1:0] valid, input int exp_src,
                           input logic rd, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                           input logic [DW-1:0] exp_data, input logic exp_err, input int exp_lat);
        int n, lat;
        bit ok;
        load_reqs(exp_src, rd, addr, wdata);
        bus.req_valid = valid;
        wait_grant(n, ok);
        check({tag, "_grant_seen"}, 64'(ok), 64'(1));
        if (!ok) begin
            bus.req_valid = '0;
            return;
        end
        check({tag, "_src_out"},  64'(bus.reg_src_out),     64'(exp_src));
        check({tag, "_addr_out"}, 64'(bus.reg_addr_out),    64'(addr));
        check({tag, "_data_out"}, 64'(bus.reg_data_out),    64'(wdata));
        check({tag, "_rdwr_out"}, 64'(bus.reg_rd_wr_L_out), 64'(rd));
        check({tag, "_ack_out"},  64'(bus.reg_ack_out),     64'(0));
        @(negedge clk);
        check({tag, "_pulse_end"}, 64'({bus.reg_req_out, bus.reg_src_out, bus.reg_addr_out}), 64'(0));
        wait_done(2, lat, ok);
        check({tag, "_done_seen"}, 64'(ok), 64'(1));
        check({tag, "_done_vec"},  64'(bus.req_done), 64'(1) << exp_src);
        check({tag, "_rsp_data"},  64'(bus.rsp_data), 64'(exp_data));
        check({tag, "_rsp_err"},   64'(bus.rsp_err),  64'(exp_err));
        check({tag, "_latency"},   64'(lat),          64'(exp_lat));
        $display("txn %s src=%0d data=%h err=%0b lat=%0d", tag, exp_src, bus.rsp_data, bus.rsp_err, lat);
        bus.req_valid = '0;
        @(negedge clk);
        check({tag, "_done_one_cycle"}, 64'(bus.req_done), 64'(0));
    endtask

    typedef struct {
        string         tag;
        logic [NR-1:0] valid;
        int            exp_src;
        logic          rd;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] exp_data;
        logic          exp_err;
        int            exp_lat;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int  n, lat;
        bit  ok;

        vecs[0] = '{"rd_r1",      4'b0010, 1, 1'b1, 23'h000002, 32'h0000_0000, 32'h1234_5678, 1'b0, 5};
        vecs[1] = '{"wr_unmap_r0", 4'b0001, 0, 1'b0, 23'h000010, 32'hA5A5_A5A5, 32'hDEAD_BEEF, 1'b1, 5};
        vecs[2] = '{"wr_hit_r3",  4'b1000, 3, 1'b0, 23'h000002, 32'h1122_3344, 32'h1122_3344, 1'b0, 5};
        vecs[3] = '{"rd_r2",      4'b0100, 2, 1'b1, 23'h000002, 32'h0000_0000, 32'h1234_5678, 1'b0, 5};
        vecs[4] = '{"rr_after2",  4'b0110, 1, 1'b1, 23'h000002, 32'h0000_0000, 32'h1234_5678, 1'b0, 5};
        vecs[5] = '{"rr_after1",  4'b1001, 3, 1'b1, 23'h000055, 32'h0000_0000, 32'hDEAD_BEEF, 1'b1, 5};

        bus.req_valid   = '0;
        bus.req_rd_wr_L = '0;
        bus.req_addr    = '0;
        bus.req_data    = '0;

        // Reset state
        @(negedge clk);
        check("rst_done",     64'(bus.req_done),    64'(0));
        check("rst_rsp",      64'({bus.rsp_err, bus.rsp_data}), 64'(0));
        check("rst_ring_out", 64'({bus.reg_req_out, bus.reg_ack_out, bus.reg_rd_wr_L_out,
                                   bus.reg_src_out, bus.reg_addr_out}), 64'(0));
        check("rst_ring_data", 64'(bus.reg_data_out), 64'(0));
        reset_n = 1'b1;
        @(negedge clk);
        check("idle_no_req", 64'(bus.reg_req_out), 64'(0));

        // Fairness with all requesters held
        for (int i = 0; i < NR; i++) begin
            bus.req_rd_wr_L[i]       = 1'b1;
            bus.req_addr[i*AW +: AW] = 23'h000002;
            bus.req_data[i*DW +: DW] = 32'h0;
        end
        bus.req_valid = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            wait_grant(n, ok);
            check("fair_grant_seen", 64'(ok), 64'(1));
            if (i > 0) check("fair_gap", 64'(n), 64'(2));
            check("fair_src", 64'(bus.reg_src_out), 64'(i % NR));
            wait_done(1, lat, ok);
            check("fair_done_vec", 64'(bus.req_done), 64'(1) << (i % NR));
            check("fair_latency", 64'(lat), 64'(5));
            $display("txn fair%0d src=%0d data=%h err=%0b lat=%0d", i, i % NR, bus.rsp_data, bus.rsp_err, lat);
        end
        bus.req_valid = '0;
        @(negedge clk);

        for (int v = 0; v < 6; v++) begin
            run_txn(vecs[v].tag, vecs[v].valid, vecs[v].exp_src, vecs[v].rd, vecs[v].addr,
                    vecs[v].wdata, vecs[v].exp_data, vecs[v].exp_err, vecs[v].exp_lat);
        end

        // Broken ring: timeout after TIMEOUT-1 counts
        ring_break = 1'b1;
        run_txn("timeout_r0", 4'b0001, 0, 1'b1, 23'h000002, 32'h0, 32'hDEAD_BEEF, 1'b1, 17);
        ring_break = 1'b0;

        // Late return while IDLE
        @(negedge clk);
        inj       = '{req: 1'b1, ack: 1'b1, rd_wr_L: 1'b1, addr: 23'h000002, data: 32'hCAFE_F00D, src: 2'd0};
        inject_en = 1'b1;
        @(negedge clk);
        inject_en = 1'b0;
        check("late_no_done", 64'(bus.req_done), 64'(0));
        @(negedge clk);
        check("late_no_done2", 64'(bus.req_done), 64'(0));
        check("late_rsp_kept", 64'({bus.rsp_err, bus.rsp_data}), {31'h0, 1'b1, 32'hDEAD_BEEF});
        $display("txn late_return ignored done=%b", bus.req_done);

        // Stray src=2 return while waiting for requester 0
        load_reqs(0, 1'b1, 23'h000002, 32'h0);
        bus.req_valid = 4'b0001;
        wait_grant(n, ok);
        check("stray_grant_seen", 64'(ok), 64'(1));
        check("stray_src", 64'(bus.reg_src_out), 64'(0));
        @(negedge clk);
        inj       = '{req: 1'b1, ack: 1'b1, rd_wr_L: 1'b1, addr: 23'h000002, data: 32'hBAD0_BAD0, src: 2'd2};
        inject_en = 1'b1;
        @(negedge clk);
        inject_en = 1'b0;
        check("stray_no_done", 64'(bus.req_done), 64'(0));
        wait_done(3, lat, ok);
        check("stray_done_vec", 64'(bus.req_done), 64'(1));
        check("stray_rsp_data", 64'(bus.rsp_data), 64'(32'h1234_5678));
        check("stray_rsp_err",  64'(bus.rsp_err),  64'(0));
        check("stray_latency",  64'(lat),          64'(5));
        $display("txn stray src=0 data=%h err=%0b lat=%0d", bus.rsp_data, bus.rsp_err, lat);
        bus.req_valid = '0;
        @(negedge clk);

        // Reset mid-WAIT for requester 1
        load_reqs(1, 1'b1, 23'h000002, 32'h0);
        bus.req_valid = 4'b0010;
        wait_grant(n, ok);
        check("rstw_grant_src", 64'(bus.reg_src_out), 64'(1));
        @(negedge clk);
        @(negedge clk);
        reset_n       = 1'b0;
        bus.req_valid = '0;
        #1;
        check("rstw_async_rsp",  64'({bus.rsp_err, bus.rsp_data}), 64'(0));
        check("rstw_async_done", 64'(bus.req_done), 64'(0));
        @(negedge clk);
        reset_n = 1'b1;
        load_reqs(0, 1'b1, 23'h000002, 32'h0);
        bus.req_valid = 4'b0101;
        wait_grant(n, ok);
        check("rstw_regrant_seen", 64'(ok), 64'(1));
        check("rstw_regrant_src",  64'(bus.reg_src_out), 64'(0));
        check("rstw_inflight_ignored", 64'(bus.req_done), 64'(0));
        wait_done(1, lat, ok);
        check("rstw_done_vec",  64'(bus.req_done), 64'(1));
        check("rstw_rsp_data",  64'(bus.rsp_data), 64'(32'h1234_5678));
        check("rstw_latency",   64'(lat),          64'(5));
        $display("txn after_reset src=0 data=%h err=%0b lat=%0d", bus.rsp_data, bus.rsp_err, lat);
        bus.req_valid = '0;
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
